// File: rtl/regfile_write_queue_if.sv
// Handshake, retirement and forwarding-lookup signals between the write-back
// stage and the register file write queue.
interface regfile_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          IN_VALID;
  logic          IN_READY;
  logic [AW-1:0] IN_ADDR;
  logic [DW-1:0] IN_DATA;
  logic          STALL;

  logic [DW-1:0] PW;
  logic [AW-1:0] RW;
  logic          E;

  logic [AW-1:0] LA, LB, LC;
  logic          HA, HB, HC;
  logic [DW-1:0] FA, FB, FC;

  logic [CW-1:0] COUNT;
  logic          FULL;
  logic          EMPTY;

  // Producer side: pipeline write-back and operand lookup logic.
  modport master (
    output IN_VALID, IN_ADDR, IN_DATA, STALL, LA, LB, LC,
    input  IN_READY, PW, RW, E, HA, HB, HC, FA, FB, FC, COUNT, FULL, EMPTY
  );

  // Queue side.
  modport slave (
    input  IN_VALID, IN_ADDR, IN_DATA, STALL, LA, LB, LC,
    output IN_READY, PW, RW, E, HA, HB, HC, FA, FB, FC, COUNT, FULL, EMPTY
  );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file write port, one
// retirement per cycle, with three forwarding lookups that return the newest
// pending value for a register.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_write_queue_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PTRW-1:0]  head_q;
  logic [PTRW-1:0]  tail_q;
  logic [CW-1:0]    count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status and retirement control depend only on stored state and STALL.
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign pop           = !empty && !bus.STALL;
  assign push          = bus.IN_VALID && !full;
  assign bus.IN_READY  = !full;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.COUNT     = count_q;
  assign bus.E         = pop;
  assign bus.PW        = data_q[head_q];
  assign bus.RW        = addr_q[head_q];

  // Walk from head to tail so the youngest matching entry overwrites older
  // ones; the retiring head still counts as pending.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] la);
    logic [DW:0]     res;
    logic [PTRW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTRW'(i);
      if (valid_q[idx] && addr_q[idx] == la) begin
        res = {1'b1, data_q[idx]};
      end
    end
    return res;
  endfunction

  // Forwarding lookups against queued entries only, never the incoming push.
  always_comb begin
    logic [DW:0] ra, rb, rc;
    ra = lookup(bus.LA);
    rb = lookup(bus.LB);
    rc = lookup(bus.LC);
    bus.HA = ra[DW];
    bus.FA = ra[DW-1:0];
    bus.HB = rb[DW];
    bus.FB = rb[DW-1:0];
    bus.HC = rc[DW];
    bus.FC = rc[DW-1:0];
  end

  // Queue storage, pointers and occupancy; reset discards pending writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: that would need the queue
      // to be both full (push refused) and empty (no pop).
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTRW'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= bus.IN_ADDR;
        data_q[tail_q]  <= bus.IN_DATA;
        tail_q          <= tail_q + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with hand-computed expectations.
module tb_regfile_write_queue;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  regfile_write_queue_if #(.DEPTH(4), .DW(32), .AW(4)) bus ();

  regfile_write_queue #(.DEPTH(4), .DW(32), .AW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [3:0] a, input logic [31:0] d);
    bus.IN_VALID = v;
    bus.IN_ADDR  = a;
    bus.IN_DATA  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST       = 1'b1;
    bus.STALL = 1'b0;
    bus.LA    = 4'd7;
    bus.LB    = 4'd0;
    bus.LC    = 4'd0;
    drive_push(1'b1, 4'd7, 32'h12345678);

    // Reset held two cycles with IN_VALID high
    tick();
    tick();
    chk("rst_E",     64'(bus.E), 64'(0));
    chk("rst_COUNT", 64'(bus.COUNT), 64'(0));
    chk("rst_READY", 64'(bus.IN_READY), 64'(1));
    chk("rst_EMPTY", 64'(bus.EMPTY), 64'(1));
    chk("rst_FULL",  64'(bus.FULL), 64'(0));
    chk("rst_PW",    64'(bus.PW), 64'(0));
    chk("rst_RW",    64'(bus.RW), 64'(0));
    chk("rst_HA",    64'(bus.HA), 64'(0));
    chk("rst_FA",    64'(bus.FA), 64'(0));
    RST = 1'b0;
    drive_push(1'b0, 4'd0, 32'h0);
    tick();
    chk("rst_nothing_queued", 64'(bus.COUNT), 64'(0));

    // Single write
    drive_push(1'b1, 4'd5, 32'hAABBCCDD);
    tick();
    drive_push(1'b0, 4'd0, 32'h0);
    settle();
    chk("single_E",     64'(bus.E), 64'(1));
    chk("single_RW",    64'(bus.RW), 64'(5));
    chk("single_PW",    64'(bus.PW), 64'(32'hAABBCCDD));
    chk("single_COUNT", 64'(bus.COUNT), 64'(1));
    tick();
    chk("single_done_E",     64'(bus.E), 64'(0));
    chk("single_done_COUNT", 64'(bus.COUNT), 64'(0));

    // Fill under STALL, then overflow attempt
    bus.STALL = 1'b1;
    drive_push(1'b1, 4'd5, 32'hAABBCCDD);
    tick();
    chk("fill1_E_stalled", 64'(bus.E), 64'(0));
    drive_push(1'b1, 4'd10, 32'h11223344);
    tick();
    drive_push(1'b1, 4'd15, 32'hFFFFFFFF);
    tick();
    drive_push(1'b1, 4'd5, 32'h01020304);
    tick();
    drive_push(1'b1, 4'd3, 32'hDEADBEEF);
    settle();
    chk("full_FULL",  64'(bus.FULL), 64'(1));
    chk("full_READY", 64'(bus.IN_READY), 64'(0));
    chk("full_COUNT", 64'(bus.COUNT), 64'(4));
    chk("full_E",     64'(bus.E), 64'(0));
    tick();
    drive_push(1'b0, 4'd0, 32'h0);
    settle();
    chk("overflow_dropped_COUNT", 64'(bus.COUNT), 64'(4));
    chk("stall_RW_stable", 64'(bus.RW), 64'(5));
    chk("stall_PW_stable", 64'(bus.PW), 64'(32'hAABBCCDD));

    // Forwarding with four entries held
    bus.LA = 4'd5;
    bus.LB = 4'd15;
    bus.LC = 4'd3;
    settle();
    chk("fwd_HA", 64'(bus.HA), 64'(1));
    chk("fwd_FA_youngest", 64'(bus.FA), 64'(32'h01020304));
    chk("fwd_HB", 64'(bus.HB), 64'(1));
    chk("fwd_FB", 64'(bus.FB), 64'(32'hFFFFFFFF));
    chk("fwd_HC_miss", 64'(bus.HC), 64'(0));
    chk("fwd_FC_miss", 64'(bus.FC), 64'(0));
    bus.LC = 4'd10;
    settle();
    chk("fwd_FC_10", 64'(bus.FC), 64'(32'h11223344));

    // Release STALL: four retirements in order
    bus.STALL = 1'b0;
    settle();
    chk("drain0_E",  64'(bus.E), 64'(1));
    chk("drain0_RW", 64'(bus.RW), 64'(5));
    chk("drain0_PW", 64'(bus.PW), 64'(32'hAABBCCDD));
    tick();
    chk("drain1_E",  64'(bus.E), 64'(1));
    chk("drain1_RW", 64'(bus.RW), 64'(10));
    chk("drain1_PW", 64'(bus.PW), 64'(32'h11223344));
    tick();
    chk("drain2_E",  64'(bus.E), 64'(1));
    chk("drain2_RW", 64'(bus.RW), 64'(15));
    chk("drain2_PW", 64'(bus.PW), 64'(32'hFFFFFFFF));
    tick();
    chk("drain3_E",  64'(bus.E), 64'(1));
    chk("drain3_RW", 64'(bus.RW), 64'(5));
    chk("drain3_PW", 64'(bus.PW), 64'(32'h01020304));
    chk("drain3_head_pending_HA", 64'(bus.HA), 64'(1));
    chk("drain3_head_pending_FA", 64'(bus.FA), 64'(32'h01020304));
    tick();
    chk("drained_E",     64'(bus.E), 64'(0));
    chk("drained_COUNT", 64'(bus.COUNT), 64'(0));
    chk("drained_EMPTY", 64'(bus.EMPTY), 64'(1));
    chk("drained_HA",    64'(bus.HA), 64'(0));

    // Streaming: one push per cycle, retiring one cycle behind
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive_push(1'b1, 4'(k), 32'hC0DE0000 + 32'(k));
      else       drive_push(1'b0, 4'd0, 32'h0);
      bus.LA = 4'(k);
      settle();
      chk("stream_in_push_not_seen", 64'(bus.HA), 64'(0));
      if (k == 0) begin
        chk("stream_first_COUNT", 64'(bus.COUNT), 64'(0));
      end else begin
        chk("stream_E",     64'(bus.E), 64'(1));
        chk("stream_COUNT", 64'(bus.COUNT), 64'(1));
        chk("stream_RW",    64'(bus.RW), 64'(k - 1));
        chk("stream_PW",    64'(bus.PW), 64'(32'hC0DE0000 + 32'(k - 1)));
      end
      tick();
    end
    chk("stream_end_COUNT", 64'(bus.COUNT), 64'(0));
    chk("stream_end_E",     64'(bus.E), 64'(0));

    // Reset in the middle of a stalled queue
    bus.STALL = 1'b1;
    drive_push(1'b1, 4'd2, 32'h00000002);
    tick();
    drive_push(1'b1, 4'd4, 32'h00000004);
    tick();
    drive_push(1'b1, 4'd6, 32'h00000006);
    tick();
    drive_push(1'b1, 4'd9, 32'h00000009);
    bus.LA = 4'd4;
    bus.LB = 4'd2;
    settle();
    chk("mid_COUNT", 64'(bus.COUNT), 64'(3));
    chk("mid_HA",    64'(bus.HA), 64'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive_push(1'b0, 4'd0, 32'h0);
    settle();
    chk("midrst_COUNT", 64'(bus.COUNT), 64'(0));
    chk("midrst_EMPTY", 64'(bus.EMPTY), 64'(1));
    chk("midrst_HA",    64'(bus.HA), 64'(0));
    chk("midrst_HB",    64'(bus.HB), 64'(0));
    bus.STALL = 1'b0;
    settle();
    chk("midrst_E_after_release", 64'(bus.E), 64'(0));
    tick();
    chk("midrst_E_next", 64'(bus.E), 64'(0));
    chk("midrst_COUNT_next", 64'(bus.COUNT), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
